// File: rtl/matinv_pkg.sv
// Shared definitions for the matrix-inversion byte-serial front and back ends:
// default geometry, frame byte count and the common state encoding.
package matinv_pkg;

   localparam int ELEM_W_DEF = 16;
   localparam int DIM_DEF    = 3;

   function automatic int nbytes(input int elem_w, input int dim);
      return dim * dim * elem_w / 8;
   endfunction

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_CHECK   = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/serial_to_parallel_matrix_loader_byte_shift_accum.sv
// NBYTES-deep byte shift register (new bytes enter the LSB lane) with a
// frame byte counter and a terminal-count flag.
module byte_shift_accum #(
   parameter int NBYTES = 18,
   parameter int TERM   = 18,
   parameter int CW     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                start,
   input  logic                push,
   input  logic                shift,
   input  logic [7:0]          in_byte,
   output logic [NBYTES*8-1:0] data,
   output logic [CW-1:0]       count,
   output logic                terminal
);

   logic [NBYTES*8-1:0] data_reg;
   logic [NBYTES*8-1:0] data_next;
   logic [CW-1:0]       count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         if (gi == 0) begin : g_first
            assign data_next[7:0] = shift ? in_byte : data_reg[7:0];
         end else begin : g_next
            assign data_next[gi*8 +: 8] = shift ? data_reg[(gi-1)*8 +: 8]
                                                : data_reg[gi*8 +: 8];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_reg  <= '0;
         count_reg <= '0;
      end else begin
         data_reg <= data_next;
         // start wins over push: a sof byte always opens a new frame at count 1
         if (clr)
            count_reg <= '0;
         else if (start)
            count_reg <= CW'(1);
         else if (push)
            count_reg <= count_reg + CW'(1);
      end
   end

   assign data     = data_reg;
   assign count    = count_reg;
   assign terminal = (count_reg == CW'(TERM));

endmodule

// File: rtl/serial_to_parallel_matrix_loader.sv
// Collects a sof-delimited byte stream into a flat DIM x DIM matrix word with
// valid/ready output. Define CHECKSUM_EN to append and verify an XOR checksum byte.
module serial_to_parallel_matrix_loader
   import matinv_pkg::*;
#(
   parameter int ELEM_W = ELEM_W_DEF,
   parameter int DIM    = DIM_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_byte,
   input  logic                     in_valid,
   input  logic                     in_sof,
   output logic                     in_ready,
   output logic [DIM*DIM*ELEM_W-1:0] out_matrix,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     frame_err
);

   localparam int NBYTES = nbytes(ELEM_W, DIM);
   localparam int MW     = DIM * DIM * ELEM_W;
`ifdef CHECKSUM_EN
   localparam int FRAME_LEN = NBYTES + 1;
`else
   localparam int FRAME_LEN = NBYTES;
`endif
   localparam int CW = $clog2(FRAME_LEN + 1);

   state_t          state_reg, state_next;
   logic [MW-1:0]   out_matrix_reg, out_matrix_next;
   logic            out_valid_reg, out_valid_next;
   logic            frame_err_reg, frame_err_next;
   logic            acc_clr, acc_start, acc_push, acc_shift, acc_term;
   logic [MW-1:0]   acc_data;
   logic [CW-1:0]   acc_count;
   logic            accept;
`ifdef CHECKSUM_EN
   logic [7:0]      xor_reg, xor_next;
   logic            chk_ok_reg, chk_ok_next;
`endif

   byte_shift_accum #(
      .NBYTES (NBYTES),
      .TERM   (FRAME_LEN),
      .CW     (CW)
   ) u_accum (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .start    (acc_start),
      .push     (acc_push),
      .shift    (acc_shift),
      .in_byte  (in_byte),
      .data     (acc_data),
      .count    (acc_count),
      .terminal (acc_term)
   );

   // Terminal count closes the input a cycle before the frame is published
   assign in_ready = rst && (state_reg == ST_COLLECT) && !acc_term;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_next      = state_reg;
      out_matrix_next = out_matrix_reg;
      out_valid_next  = out_valid_reg;
      frame_err_next  = 1'b0;
      acc_clr         = 1'b0;
      acc_start       = 1'b0;
      acc_push        = 1'b0;
      acc_shift       = 1'b0;
`ifdef CHECKSUM_EN
      xor_next        = xor_reg;
      chk_ok_next     = chk_ok_reg;
`endif
      case (state_reg)
         ST_COLLECT: begin
            if (acc_term) begin
`ifdef CHECKSUM_EN
               state_next      = ST_CHECK;
`else
               out_matrix_next = acc_data;
               out_valid_next  = 1'b1;
               state_next      = ST_HOLD;
`endif
            end else if (accept) begin
               if (in_sof) begin
                  acc_start      = 1'b1;
                  acc_shift      = 1'b1;
                  frame_err_next = (acc_count != '0);
`ifdef CHECKSUM_EN
                  xor_next       = in_byte;
`endif
               end else if (acc_count == '0) begin
                  frame_err_next = 1'b1;
               end else begin
                  acc_push = 1'b1;
`ifdef CHECKSUM_EN
                  // The checksum byte is counted but kept out of the matrix
                  if (acc_count == CW'(NBYTES)) begin
                     chk_ok_next = (xor_reg == in_byte);
                  end else begin
                     acc_shift = 1'b1;
                     xor_next  = xor_reg ^ in_byte;
                  end
`else
                  acc_shift = 1'b1;
`endif
               end
            end
         end
`ifdef CHECKSUM_EN
         ST_CHECK: begin
            if (chk_ok_reg) begin
               out_matrix_next = acc_data;
               out_valid_next  = 1'b1;
               state_next      = ST_HOLD;
            end else begin
               frame_err_next = 1'b1;
               acc_clr        = 1'b1;
               state_next     = ST_COLLECT;
            end
         end
`endif
         ST_HOLD: begin
            if (out_valid_reg && out_ready) begin
               out_valid_next = 1'b0;
               acc_clr        = 1'b1;
               state_next     = ST_COLLECT;
            end
         end
         default: begin
            state_next = ST_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ST_COLLECT;
         out_matrix_reg <= '0;
         out_valid_reg  <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         out_matrix_reg <= out_matrix_next;
         out_valid_reg  <= out_valid_next;
         frame_err_reg  <= frame_err_next;
      end
   end

`ifdef CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         xor_reg    <= '0;
         chk_ok_reg <= 1'b0;
      end else begin
         xor_reg    <= xor_next;
         chk_ok_reg <= chk_ok_next;
      end
   end
`endif

   assign out_matrix = out_matrix_reg;
   assign out_valid  = out_valid_reg;
   assign frame_err  = frame_err_reg;

endmodule
